uart_tx_driver: RTL and testbench
=================================

UART_TX_DRIVER -- requirements
Module: uart_tx_driver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, the number of clk cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port wdata, input, 8 bits: byte to transmit, taken from io_wdata[7:0].
REQ-005 SHALL have port sel, input, 1 bit: one-hot IO page select bit for this peripheral (io_word_address[1], 0x0000.4002).
REQ-006 SHALL have port wstrb, input, 1 bit: IO write strobe.
REQ-007 SHALL have port rstrb, input, 1 bit: IO read strobe.
REQ-008 SHALL have port rdata, output, 32 bits: status word, OR-combined by the SoC into io_rdata.
REQ-009 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 SHALL have port tx_done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-012 Accept: sel & wstrb & state==IDLE at edge N -> latch wdata into shift register, state START, tx=0 and busy=1 from edge N (visible cycle N+1).
REQ-013 Write while not IDLE (busy) SHALL be ignored: no data change, no frame restart, no error flag.
REQ-014 Write with sel=0 or wstrb=0 SHALL have no effect.
REQ-015 Baud counter counts 0..CLKS_PER_BIT-1 and clears on every bit boundary; each bit SHALL hold tx for exactly CLKS_PER_BIT cycles.
REQ-016 START: tx=0 for one bit time, then DATA with bit index 0.
REQ-017 DATA: tx = shift_reg[0], LSB first; shift right at each bit boundary; 3-bit index wraps from 7 to STOP after the 8th bit.
REQ-018 STOP: tx=1 for one bit time, then IDLE.
REQ-019 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles from tx falling to busy deasserting.
REQ-020 tx_done SHALL pulse high for exactly one cycle, the first cycle in IDLE after STOP.
REQ-021 Write arriving in the same cycle as the STOP->IDLE transition SHALL be ignored (state not yet IDLE); a write one cycle later SHALL be accepted, giving back-to-back frames with zero idle bits.
REQ-022 rdata = {31'b0, busy} when sel=1, else 32'h0; combinational, rstrb not required to gate it.
REQ-023 busy SHALL equal (state != IDLE).
REQ-024 tx SHALL be registered; no combinational path from any input to tx.

Reset
REQ-025 rst=1 at an edge SHALL force state IDLE, tx=1, tx_done=0, busy=0, baud counter=0, bit index=0, shift register=0.
REQ-026 rst SHALL override a simultaneous write; no frame starts.
REQ-027 rst asserted mid-frame SHALL abort the frame: tx=1 from the next cycle, no tx_done pulse.

Verification
REQ-028 CLKS_PER_BIT=4, write 0xA5 -> tx per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; tx_done pulses at cycle 41 after the accepting edge.
REQ-029 Write 0x3C during DATA of a 0xA5 frame -> 0xA5 frame unchanged; no second frame.
REQ-030 Write 0x00 one cycle after tx_done -> second frame begins immediately; tx stays low for 9 bit times, then stop.
REQ-031 Read with sel=1 mid-frame -> rdata=32'h1; idle -> 32'h0; sel=0 -> 32'h0 always.
REQ-032 rst pulse at cycle 15 of a frame -> tx=1 the following cycle, busy=0, no tx_done; next write accepted normally.
REQ-033 CLKS_PER_BIT=2 (minimum), write 0xFF -> tx low 2 cycles, high 18 cycles; frame 20 cycles.

Source files
------------

// File: rtl/uart_tx_driver.sv
// rtl/uart_tx_driver.sv - memory-mapped 8N1 UART transmitter with busy status
// A single IO write starts a frame when idle; tx is fully registered.
module uart_tx_driver #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  wdata,
  input  logic        sel,
  input  logic        wstrb,
  input  logic        rstrb,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        tx_done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic        tx_n, done_n;
  logic        bit_end;
  logic        busy;
  logic        unused_rstrb;

  // Status reads are side-effect free, so the read strobe is not needed.
  assign unused_rstrb = rstrb;

  assign bit_end = (cnt == LAST_CNT);
  assign busy    = (state != IDLE);
  assign rdata   = sel ? {31'b0, busy} : 32'h0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    tx_n    = tx;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (sel && wstrb) begin
          state_n = START;
          shift_n = wdata;
          cnt_n   = 16'd0;
          idx_n   = 3'd0;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = 16'd0;
          tx_n    = shift[0];
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = 16'd0;
          idx_n   = idx + 3'd1;
          shift_n = {1'b0, shift[7:1]};
          // tx is registered, so the next data bit comes from shift[1].
          if (idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            tx_n = shift[1];
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          cnt_n   = 16'd0;
          tx_n    = 1'b1;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      idx     <= 3'd0;
      shift   <= 8'd0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
      tx_done <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_driver.sv
// tb/tb_uart_tx_driver.sv - directed bench for uart_tx_driver at 4 and 2 clocks per bit
// Expected line levels come from the {stop, data, start} frame built per byte.
module tb_uart_tx_driver;

  logic        clk = 1'b0;
  logic        rst, sel4, sel2, wstrb, rstrb;
  logic [7:0]  wdata;
  logic [31:0] rdata4, rdata2;
  logic        tx4, tx2, done4, done2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  uart_tx_driver #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .wdata(wdata), .sel(sel4), .wstrb(wstrb),
    .rstrb(rstrb), .rdata(rdata4), .tx(tx4), .tx_done(done4)
  );

  uart_tx_driver #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst(rst), .wdata(wdata), .sel(sel2), .wstrb(wstrb),
    .rstrb(rstrb), .rdata(rdata2), .tx(tx2), .tx_done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle after the accepting edge.
  task automatic put_write(input logic [7:0] d);
    wdata = d;
    wstrb = 1'b1;
    step();
    wstrb = 1'b0;
  endtask

  // Follows one frame cycle by cycle; inj selects a cycle in which a write is driven.
  task automatic watch(input int cpb, input logic [7:0] d, input int inj,
                       input logic [7:0] inj_d, input string tag);
    logic [9:0]  fr;
    logic        t, dn;
    logic [31:0] rd;
    int          n;
    fr = {1'b1, d, 1'b0};
    n  = 10 * cpb;
    for (int k = 1; k <= n + 1; k++) begin
      wstrb = 1'b0;
      t  = (cpb == 4) ? tx4 : tx2;
      dn = (cpb == 4) ? done4 : done2;
      rd = (cpb == 4) ? rdata4 : rdata2;
      if (k <= n) begin
        check($sformatf("%s tx c%0d", tag, k), {31'b0, t}, {31'b0, fr[(k-1)/cpb]});
        check($sformatf("%s done c%0d", tag, k), {31'b0, dn}, 32'h0);
        check($sformatf("%s busy c%0d", tag, k), rd, 32'h1);
      end else begin
        check($sformatf("%s done_pulse", tag), {31'b0, dn}, 32'h1);
        check($sformatf("%s idle_busy", tag), rd, 32'h0);
        check($sformatf("%s idle_tx", tag), {31'b0, t}, 32'h1);
      end
      if (k == n / 2) begin
        if (cpb == 4) sel4 = 1'b0; else sel2 = 1'b0;
        #1;
        rd = (cpb == 4) ? rdata4 : rdata2;
        check($sformatf("%s rdata_sel0", tag), rd, 32'h0);
        if (cpb == 4) sel4 = 1'b1; else sel2 = 1'b1;
      end
      if (k == inj) begin
        wdata = inj_d;
        wstrb = 1'b1;
      end
      step();
    end
    wstrb = 1'b0;
    if (inj != n + 1) begin
      t  = (cpb == 4) ? tx4 : tx2;
      dn = (cpb == 4) ? done4 : done2;
      rd = (cpb == 4) ? rdata4 : rdata2;
      check($sformatf("%s after_tx", tag), {31'b0, t}, 32'h1);
      check($sformatf("%s after_done", tag), {31'b0, dn}, 32'h0);
      check($sformatf("%s after_busy", tag), rd, 32'h0);
    end
  endtask

  initial begin
    logic seen_done;
    rst   = 1'b1;
    sel4  = 1'b1;
    sel2  = 1'b0;
    wstrb = 1'b1;
    rstrb = 1'b0;
    wdata = 8'h55;
    repeat (3) step();
    wstrb = 1'b0;
    rst   = 1'b0;
    check("reset tx4", {31'b0, tx4}, 32'h1);
    check("reset tx2", {31'b0, tx2}, 32'h1);
    check("reset done4", {31'b0, done4}, 32'h0);
    check("reset busy4", rdata4, 32'h0);
    check("reset rdata2 sel0", rdata2, 32'h0);
    step();
    check("post reset busy4", rdata4, 32'h0);

    sel4  = 1'b0;
    wstrb = 1'b1;
    wdata = 8'h12;
    step();
    wstrb = 1'b0;
    sel4  = 1'b1;
    check("sel0 write busy", rdata4, 32'h0);
    check("sel0 write tx", {31'b0, tx4}, 32'h1);
    step();
    check("nostrobe busy", rdata4, 32'h0);

    rstrb = 1'b1;
    put_write(8'hA5);
    watch(4, 8'hA5, 15, 8'h3C, "a5");
    rstrb = 1'b0;

    put_write(8'h5A);
    watch(4, 8'h5A, 40, 8'hFF, "5a");

    put_write(8'hC3);
    watch(4, 8'hC3, 41, 8'h00, "c3");
    watch(4, 8'h00, 0, 8'h00, "b2b00");

    put_write(8'h96);
    repeat (14) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort tx", {31'b0, tx4}, 32'h1);
    check("abort busy", rdata4, 32'h0);
    check("abort done", {31'b0, done4}, 32'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 45; i++) begin
      seen_done = seen_done | done4 | ~tx4;
      step();
    end
    check("abort quiet", {31'b0, seen_done}, 32'h0);
    put_write(8'h0F);
    watch(4, 8'h0F, 0, 8'h00, "0f");

    sel4 = 1'b0;
    sel2 = 1'b1;
    put_write(8'hFF);
    check("cpb4 unselected", rdata4, 32'h0);
    watch(2, 8'hFF, 0, 8'h00, "ff2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
